// File: rtl/capture_scheduler.sv
// Ping-pong frame-buffer scheduler between the capture block and the QR decoder.
// Steers capture writes into a free bank, hands full banks to the decoder, and
// aborts decodes that overrun a watchdog.
//
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, synchronous active-low reset
//   s00_cap_wea/addr/data            : capture block BRAM write port
//   m00_bram_wea/address/data        : gated two-bank BRAM write port
//   m00_start_capture                : 1-cycle pulse re-arming capture
//   m00_cap_bank                     : bank currently targeted by capture
//   m00_dec_start/m00_dec_bank       : decoder dispatch pulse and bank
//   s00_dec_done                     : decoder finished pulse
//   m00_dec_abort                    : decode watchdog expiry pulse
//   m00_bank_full                    : per-bank full flags
//   m00_frames_done/m00_timeouts     : decoded-frame / abort counters
module capture_scheduler #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int DEC_TIMEOUT  = 16777216
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_aresetn,
    input  logic              s00_cap_wea,
    input  logic [ADDR_W-1:0] s00_cap_addr,
    input  logic              s00_cap_data,
    output logic              m00_start_capture,
    output logic              m00_bram_wea,
    output logic [ADDR_W:0]   m00_bram_address,
    output logic              m00_bram_data,
    output logic              m00_cap_bank,
    output logic              m00_dec_start,
    output logic              m00_dec_bank,
    input  logic              s00_dec_done,
    output logic              m00_dec_abort,
    output logic [1:0]        m00_bank_full,
    output logic [15:0]       m00_frames_done,
    output logic [7:0]        m00_timeouts
);

    localparam int CNT_W = $clog2(FRAME_PIXELS);
    localparam int TMR_W = $clog2(DEC_TIMEOUT);

    typedef enum logic [1:0] {
        CAP_RUN,
        CAP_SWAP,
        CAP_HOLD
    } cap_state_e;

    typedef enum logic {
        D_IDLE,
        D_BUSY
    } dec_state_e;

    cap_state_e        cap_state_q, cap_state_d;
    logic              cap_bank_q, cap_bank_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              start_capture_q, start_capture_d;

    dec_state_e        dec_state_q, dec_state_d;
    logic              dec_bank_q, dec_bank_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              dec_start_q, dec_start_d;
    logic              dec_abort_q, dec_abort_d;
    logic [15:0]       frames_q, frames_d;
    logic [7:0]        touts_q, touts_d;

    logic              wea_gated;
    logic              frame_end;
    logic              other_bank;
    logic              clr_full;

    assign wea_gated  = s00_cap_wea & (cap_state_q == CAP_RUN);
    assign frame_end  = wea_gated &
                        (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));
    assign other_bank = ~cap_bank_q;

    assign m00_bram_wea      = wea_gated;
    assign m00_bram_address  = {cap_bank_q, s00_cap_addr};
    assign m00_bram_data     = s00_cap_data;
    assign m00_cap_bank      = cap_bank_q;
    assign m00_start_capture = start_capture_q;
    assign m00_dec_start     = dec_start_q;
    assign m00_dec_bank      = dec_bank_q;
    assign m00_dec_abort     = dec_abort_q;
    assign m00_bank_full     = full_q;
    assign m00_frames_done   = frames_q;
    assign m00_timeouts      = touts_q;

    // Capture FSM: SWAP and HOLD share one action; SWAP only differs in
    // that it is the first cycle after the frame completed.
    always_comb begin
        cap_state_d     = cap_state_q;
        cap_bank_d      = cap_bank_q;
        pix_cnt_d       = pix_cnt_q;
        start_capture_d = 1'b0;
        unique case (cap_state_q)
            CAP_RUN: begin
                if (frame_end) begin
                    pix_cnt_d   = '0;
                    cap_state_d = CAP_SWAP;
                end else if (wea_gated) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            CAP_SWAP, CAP_HOLD: begin
                if (!full_q[other_bank]) begin
                    cap_bank_d      = other_bank;
                    start_capture_d = 1'b1;
                    cap_state_d     = CAP_RUN;
                end else begin
                    cap_state_d = CAP_HOLD;
                end
            end
            default: cap_state_d = CAP_RUN;
        endcase
    end

    // Decode FSM. With both banks full the one not owned by capture is the
    // older frame; with one full bank, full_q[1] names it directly.
    always_comb begin
        dec_state_d = dec_state_q;
        dec_bank_d  = dec_bank_q;
        timer_d     = timer_q;
        dec_start_d = 1'b0;
        dec_abort_d = 1'b0;
        frames_d    = frames_q;
        touts_d     = touts_q;
        clr_full    = 1'b0;
        unique case (dec_state_q)
            D_IDLE: begin
                if (|full_q) begin
                    dec_bank_d  = (&full_q) ? other_bank : full_q[1];
                    dec_start_d = 1'b1;
                    timer_d     = '0;
                    dec_state_d = D_BUSY;
                end
            end
            D_BUSY: begin
                timer_d = timer_q + 1'b1;
                if (s00_dec_done) begin
                    clr_full    = 1'b1;
                    frames_d    = frames_q + 16'd1;
                    dec_state_d = D_IDLE;
                end else if (timer_q == TMR_W'(DEC_TIMEOUT - 1)) begin
                    clr_full    = 1'b1;
                    dec_abort_d = 1'b1;
                    if (touts_q != 8'hFF) begin
                        touts_d = touts_q + 8'd1;
                    end
                    dec_state_d = D_IDLE;
                end
            end
            default: dec_state_d = D_IDLE;
        endcase
    end

    // Capture only ever fills an empty bank and the decoder only clears a
    // full one, so set and clear never collide on the same bank.
    always_comb begin
        full_d = full_q;
        if (clr_full) begin
            full_d[dec_bank_q] = 1'b0;
        end
        if (frame_end) begin
            full_d[cap_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            cap_state_q     <= CAP_RUN;
            cap_bank_q      <= 1'b0;
            pix_cnt_q       <= '0;
            full_q          <= 2'b00;
            start_capture_q <= 1'b0;
            dec_state_q     <= D_IDLE;
            dec_bank_q      <= 1'b0;
            timer_q         <= '0;
            dec_start_q     <= 1'b0;
            dec_abort_q     <= 1'b0;
            frames_q        <= 16'd0;
            touts_q         <= 8'd0;
        end else begin
            cap_state_q     <= cap_state_d;
            cap_bank_q      <= cap_bank_d;
            pix_cnt_q       <= pix_cnt_d;
            full_q          <= full_d;
            start_capture_q <= start_capture_d;
            dec_state_q     <= dec_state_d;
            dec_bank_q      <= dec_bank_d;
            timer_q         <= timer_d;
            dec_start_q     <= dec_start_d;
            dec_abort_q     <= dec_abort_d;
            frames_q        <= frames_d;
            touts_q         <= touts_d;
        end
    end

endmodule

// File: tb/tb_capture_scheduler.sv
// Scoreboard bench for capture_scheduler: a frame/decode-level reference
// model predicts pulses and counters; a negedge monitor compares.
`timescale 1ns/1ps
module tb_capture_scheduler;

    localparam int FP = 4;
    localparam int AW = 17;
    localparam int DT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wea = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          data = 1'b0;
    logic          done = 1'b0;

    logic          start_cap;
    logic          bram_wea;
    logic [AW:0]   bram_addr;
    logic          bram_data;
    logic          cap_bank;
    logic          dec_start;
    logic          dec_bank;
    logic          dec_abort;
    logic [1:0]    bank_full;
    logic [15:0]   frames_done;
    logic [7:0]    timeouts;

    capture_scheduler #(
        .FRAME_PIXELS(FP),
        .ADDR_W(AW),
        .DEC_TIMEOUT(DT)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_cap_wea(wea),
        .s00_cap_addr(addr),
        .s00_cap_data(data),
        .m00_start_capture(start_cap),
        .m00_bram_wea(bram_wea),
        .m00_bram_address(bram_addr),
        .m00_bram_data(bram_data),
        .m00_cap_bank(cap_bank),
        .m00_dec_start(dec_start),
        .m00_dec_bank(dec_bank),
        .s00_dec_done(done),
        .m00_dec_abort(dec_abort),
        .m00_bank_full(bank_full),
        .m00_frames_done(frames_done),
        .m00_timeouts(timeouts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: frame counts, waiting-for-free-bank flag, decoder
    // age in cycles since dispatch.
    int          m_bank = 0;
    int          m_cnt = 0;
    bit          m_wait = 0;
    logic [1:0]  m_full = 2'b00;
    bit          m_busy = 0;
    int          m_dbank = 0;
    int          m_age = 0;
    logic [15:0] m_frames = 16'd0;
    int          m_touts = 0;

    typedef struct {
        int cyc;
        int bank;
    } ev_t;

    ev_t q_start[$];
    ev_t q_dec[$];
    ev_t q_abort[$];

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] of;
        int ob;
        cyc++;
        if (!rst_n) begin
            m_bank = 0; m_cnt = 0; m_wait = 0; m_full = 2'b00;
            m_busy = 0; m_dbank = 0; m_age = 0;
            m_frames = 16'd0; m_touts = 0;
        end else begin
            of = m_full;
            ob = m_bank;
            if (!m_wait) begin
                if (wea) begin
                    m_cnt++;
                    if (m_cnt == FP) begin
                        m_cnt = 0;
                        m_full[ob] = 1'b1;
                        m_wait = 1;
                    end
                end
            end else if (!of[1-ob]) begin
                m_bank = 1 - ob;
                m_wait = 0;
                q_start.push_back('{cyc, 0});
            end
            if (!m_busy) begin
                if (of != 2'b00) begin
                    if (of == 2'b11) m_dbank = 1 - ob;
                    else m_dbank = of[1] ? 1 : 0;
                    m_busy = 1;
                    m_age = 0;
                    q_dec.push_back('{cyc, m_dbank});
                end
            end else begin
                m_age++;
                if (done) begin
                    m_full[m_dbank] = 1'b0;
                    m_frames++;
                    m_busy = 0;
                end else if (m_age == DT) begin
                    m_full[m_dbank] = 1'b0;
                    if (m_touts < 255) m_touts++;
                    m_busy = 0;
                    q_abort.push_back('{cyc, 0});
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e;
        if (cyc > 0) begin
            chk("bram_wea", bram_wea, wea & !m_wait);
            chk("bram_addr", bram_addr, {m_bank[0], addr});
            chk("bram_data", bram_data, data);
            chk("cap_bank", cap_bank, m_bank);
            chk("bank_full", bank_full, m_full);
            chk("frames_done", frames_done, m_frames);
            chk("timeouts", timeouts, m_touts);

            e = (q_start.size() > 0 && q_start[0].cyc == cyc);
            chk("start_capture", start_cap, e);
            if (e) void'(q_start.pop_front());

            e = (q_dec.size() > 0 && q_dec[0].cyc == cyc);
            chk("dec_start", dec_start, e);
            if (e) begin
                chk("dec_bank", dec_bank, q_dec[0].bank);
                chk("dec_bank_full", bank_full[dec_bank], 1);
                checks++;
                if (dec_bank == cap_bank) begin
                    failures++;
                    $display("FAIL dec_vs_cap: dec_bank %0d equals cap_bank %0d",
                             dec_bank, cap_bank);
                end
                void'(q_dec.pop_front());
            end

            e = (q_abort.size() > 0 && q_abort[0].cyc == cyc);
            chk("dec_abort", dec_abort, e);
            if (e) void'(q_abort.pop_front());
        end
    end

    task automatic step(input bit w, input bit d);
        @(posedge clk);
        #1;
        wea  = w;
        done = d;
        addr = AW'($urandom);
        data = 1'($urandom);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_full", bank_full, 0);
        chk("rst_cap_bank", cap_bank, 0);
        chk("rst_frames", frames_done, 0);
        rst_n = 1'b1;

        // mixed random traffic, decoder finishes at random times
        for (int i = 0; i < 700; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        // done lands on the watchdog expiry cycle every time
        for (int i = 0; i < 300; i++) begin
            step(1'b1, m_busy && m_age == DT - 1);
        end

        // stalled decoder: drive the abort counter into saturation
        n = 0;
        while (m_touts < 255 && n < 8000) begin
            step($urandom_range(0, 3) != 0, 1'b0);
            n++;
        end
        chk("sat_reached", m_touts, 255);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
        #1;
        chk("timeouts_sat", timeouts, 255);

        // reset mid-frame in bank1 with a decode in flight
        n = 0;
        while (!(m_bank == 1 && m_cnt == 2 && m_busy && !m_wait)
               && n < 3000) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        chk("midframe_reached", n < 3000, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wea = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_full", bank_full, 0);
        chk("mid_rst_cap_bank", cap_bank, 0);
        chk("mid_rst_abort", dec_abort, 0);
        chk("mid_rst_touts", timeouts, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        chk("three_strobes_empty", bank_full, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
        chk("fourth_strobe_full", bank_full, 1);

        // random traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 250) != 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
Ping-pong frame-buffer scheduler between the binarized-frame capture block and the QR decoder. It owns two BRAM banks and steers capture writes into the free bank, blocking writes to a full bank. It hands each completed frame to the decoder and re-arms capture by pulsing the capture block's start_capture input. It also bounds decode time with a watchdog, so capture and decode overlap without the decoder ever reading a bank that is being written.

Parameters:
FRAME_PIXELS, 76800, pixels per frame (count of capture write strobes per frame); must be >= 2
ADDR_W, 17, width of the per-bank pixel address
DEC_TIMEOUT, 16777216, cycles allowed from m00_dec_start to s00_dec_done before abort; must be >= 2

Ports:
s00_axis_aclk  in  1  clock
s00_axis_aresetn  in  1  synchronous active-low reset
s00_cap_wea  in  1  capture block BRAM write strobe
s00_cap_addr  in  ADDR_W  capture block BRAM address
s00_cap_data  in  1  capture block BRAM data (binarized pixel)
m00_start_capture  out  1  1-cycle pulse that re-arms the capture block
m00_bram_wea  out  1  gated write enable to the two-bank BRAM
m00_bram_address  out  ADDR_W+1  {m00_cap_bank, s00_cap_addr}
m00_bram_data  out  1  s00_cap_data passthrough
m00_cap_bank  out  1  bank currently targeted by capture
m00_dec_start  out  1  1-cycle pulse: decoder may begin on m00_dec_bank
m00_dec_bank  out  1  bank handed to the decoder
s00_dec_done  in  1  1-cycle pulse from the decoder: bank consumed
m00_dec_abort  out  1  1-cycle pulse: decode watchdog expired
m00_bank_full  out  2  per-bank full flags
m00_frames_done  out  16  decoded-frame counter (wraps)
m00_timeouts  out  8  abort counter (saturates at 255)

Behaviour:
- Reset (all registers clear synchronously while s00_axis_aresetn=0):
  - capture FSM = CAP_RUN; cap_bank = 0; pix_cnt = 0; full = 2'b00; decode FSM = D_IDLE; timer = 0.
  - All registered outputs = 0.
  - No start_capture pulse follows reset, because the capture block self-arms on the same reset.
- Write path (combinational, zero latency):
  - m00_bram_wea = s00_cap_wea & (cap state == CAP_RUN).
  - Address and data pass straight through.
  - Strobes outside CAP_RUN are dropped and not counted.
- Capture FSM:
  - CAP_RUN: each gated strobe increments pix_cnt. On the strobe with pix_cnt == FRAME_PIXELS-1: set full[cap_bank], clear pix_cnt, go to CAP_SWAP.
  - CAP_SWAP (exactly 1 cycle): if full[~cap_bank] == 0, toggle cap_bank, register m00_start_capture = 1 for one cycle, go to CAP_RUN. Otherwise go to CAP_HOLD.
  - CAP_HOLD: stay until full[~cap_bank] == 0, then perform the CAP_SWAP action.
  - The swap decision always uses the registered full flags, so a bank freed in cycle N is seen in cycle N+1.
- Decode FSM:
  - D_IDLE: if any full bit is set, select a bank. If both are set, select ~cap_bank (the older frame); otherwise select the single full bank. Register m00_dec_bank, pulse m00_dec_start for one cycle, clear timer, go to D_BUSY. s00_dec_done is ignored in D_IDLE.
  - D_BUSY: timer increments every cycle.
    - s00_dec_done=1: clear full[dec_bank], frames_done += 1, go to D_IDLE.
    - Else if timer == DEC_TIMEOUT-1: pulse m00_dec_abort, clear full[dec_bank], saturating-increment timeouts, go to D_IDLE.
    - Done in the expiry cycle counts as done: no abort is issued.
  - Earliest re-dispatch is 1 cycle after returning to D_IDLE.
- Invariants (bench asserts):
  - The decoder is never dispatched to a bank whose full bit is clear.
  - When both FSMs are active, dec_bank != cap_bank.
  - The set of full[cap_bank] and the clear of full[dec_bank] never target the same bank in the same cycle.
- Reset mid-frame:
  - Partial frame is discarded and pix_cnt returns to 0.
  - Bank contents are stale but marked empty.
  - An active decode is dropped silently: no abort pulse, no counter change.

Test Plan:
1. FRAME_PIXELS=4. After reset, 4 strobes -> full=01 on the next edge; next cycle m00_start_capture=1 and cap_bank=1. m00_dec_start=1 with dec_bank=0 within 2 cycles of the last strobe.
2. Decoder busy on bank0; 4 more strobes fill bank1 -> CAP_HOLD, full=11. Further s00_cap_wea gives m00_bram_wea=0. s00_dec_done -> full=10, frames_done=1; next cycle start_capture pulses with cap_bank=0. The decoder then starts on bank1.
3. DEC_TIMEOUT=16, no done -> m00_dec_abort exactly 16 cycles after the dec_start pulse; timeouts=1; bank freed; a held capture swaps on the following cycle.
4. s00_dec_done coincides with the timer-expiry cycle -> frames_done increments, no abort, timeouts unchanged.
5. Reset asserted after 2 strobes into bank1 with a decode active -> all outputs 0 and cap_bank=0. A full 4 fresh strobes are required before full=01.
6. cap_bank=1, s00_cap_addr=3, ADDR_W=17 -> m00_bram_address=0x20003 in the same cycle. 255 forced timeouts followed by one more -> m00_timeouts holds 255.
